// File: rtl/corr_stim_gen.sv
// Stimulus source for correlation/power-analysis runs: drives SIM*SIM ordered (A,B)
// pairs onto the DUT input bus one phase at a time and strobes each trace window.
module corr_stim_gen #(
    parameter int unsigned IN_SIZE  = 8,
    parameter int unsigned SIM      = 16,
    parameter bit          FULL     = 1'b1,
    parameter int unsigned HOLD_CYC = 1,
    parameter logic [31:0] SEED     = 32'hACE1ACE1,
    localparam int unsigned NPAIR   = SIM * SIM,
    localparam int unsigned IDX_W   = (NPAIR > 1) ? $clog2(NPAIR) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
    output logic [IN_SIZE-1:0] in_o,
    output logic               sim_begin,
    output logic               sim_end,
    output logic               pair_valid,
    output logic [IN_SIZE-1:0] pair_a,
    output logic [IN_SIZE-1:0] pair_b,
    output logic [IDX_W-1:0]   sim_idx,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CNT_W     = (SIM > 1) ? $clog2(SIM) : 1;
    localparam int unsigned HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [31:0] LFSR_MASK = 32'h80200003;

    typedef enum logic [1:0] {IDLE, PH_A, PH_B, DONE} state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q;
    logic [CNT_W-1:0]   i_q, j_q, i_d, j_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        lfsr_q, lfsr_step;
    logic [IN_SIZE-1:0] in_q, cur_a_q, pair_a_q, pair_b_q, a_val, b_val;
    logic               begin_q, end_q;
    logic               hold_last, last_pair;
    logic               enter_a, enter_b, first_pair, finish_pair;

    assign hold_last = (hold_q == HOLD_W'(HOLD_CYC - 1));
    assign last_pair = (idx_q == IDX_W'(NPAIR - 1));
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: registers take <= so every flop samples pre-edge values
            state_q <= state_d;
        end
    end

    // pause gates every transition, so a frozen FSM raises no phase events
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch
        state_d     = state_q;
        enter_a     = 1'b0;
        enter_b     = 1'b0;
        first_pair  = 1'b0;
        finish_pair = 1'b0;
        busy        = (state_q == PH_A) || (state_q == PH_B);
        done        = (state_q == DONE);
        if (!pause) begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d    = PH_A;
                        enter_a    = 1'b1;
                        first_pair = 1'b1;
                    end
                end
                PH_A: begin
                    if (hold_last) begin
                        state_d = PH_B;
                        enter_b = 1'b1;
                    end
                end
                PH_B: begin
                    if (hold_last) begin
                        finish_pair = 1'b1;
                        if (last_pair) begin
                            state_d = DONE;
                        end else begin
                            state_d = PH_A;
                            enter_a = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pair counters: j is the fast index, i advances on each j wrap.
    always_comb begin
        i_d   = i_q;
        j_d   = j_q;
        idx_d = idx_q;
        if (first_pair) begin
            i_d   = '0;
            j_d   = '0;
            idx_d = '0;
        end else if (finish_pair && !last_pair) begin
            idx_d = idx_q + 1'b1;
            if (j_q == CNT_W'(SIM - 1)) begin
                j_d = '0;
                i_d = i_q + 1'b1;
            end else begin
                j_d = j_q + 1'b1;
            end
        end
    end

    assign a_val = FULL ? IN_SIZE'(i_d) : lfsr_step[IN_SIZE-1:0];
    assign b_val = FULL ? IN_SIZE'(j_q) : lfsr_step[IN_SIZE-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= '0;
            i_q      <= '0;
            j_q      <= '0;
            idx_q    <= '0;
            lfsr_q   <= SEED;
            in_q     <= '0;
            cur_a_q  <= '0;
            pair_a_q <= '0;
            pair_b_q <= '0;
            begin_q  <= 1'b0;
            end_q    <= 1'b0;
        end else if (!pause) begin
            i_q     <= i_d;
            j_q     <= j_d;
            idx_q   <= idx_d;
            begin_q <= enter_b;
            end_q   <= finish_pair;
            if (enter_a || enter_b || finish_pair) begin
                hold_q <= '0;
            end else if (busy) begin
                hold_q <= hold_q + 1'b1;
            end
            if (enter_a || enter_b) begin
                if (!FULL) begin
                    lfsr_q <= lfsr_step;
                end
                in_q <= enter_a ? a_val : b_val;
            end
            if (enter_a) begin
                cur_a_q <= a_val;
            end
            if (finish_pair) begin
                pair_a_q <= cur_a_q;
                pair_b_q <= in_q;
            end
        end
    end

    // A strobe held while paused stays pending and appears once pause drops.
    assign sim_begin  = begin_q & ~pause;
    assign sim_end    = end_q & ~pause;
    assign pair_valid = end_q & ~pause;
    assign in_o       = in_q;
    assign pair_a     = pair_a_q;
    assign pair_b     = pair_b_q;
    assign sim_idx    = idx_q;

endmodule

// File: tb/tb_corr_stim_gen.sv
// Bench for corr_stim_gen: three configurations share one random stimulus stream and
// are compared every cycle against a phase-indexed reference model.
module tb_corr_stim_gen;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n, start, pause;
    always #5 clk = ~clk;

    logic [7:0] in0, pa0, pb0, in1, pa1, pb1, in2, pa2, pb2;
    logic       sb0, se0, pv0, bz0, dn0, sb1, se1, pv1, bz1, dn1, sb2, se2, pv2, bz2, dn2;
    logic [1:0] ix0;
    logic [3:0] ix1, ix2;

    corr_stim_gen #(.IN_SIZE(8), .SIM(2), .FULL(1'b1), .HOLD_CYC(1), .SEED(32'hACE1ACE1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .in_o(in0),
        .sim_begin(sb0), .sim_end(se0), .pair_valid(pv0), .pair_a(pa0), .pair_b(pb0),
        .sim_idx(ix0), .busy(bz0), .done(dn0));
    corr_stim_gen #(.IN_SIZE(8), .SIM(3), .FULL(1'b1), .HOLD_CYC(3), .SEED(32'hACE1ACE1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .in_o(in1),
        .sim_begin(sb1), .sim_end(se1), .pair_valid(pv1), .pair_a(pa1), .pair_b(pb1),
        .sim_idx(ix1), .busy(bz1), .done(dn1));
    corr_stim_gen #(.IN_SIZE(8), .SIM(3), .FULL(1'b0), .HOLD_CYC(2), .SEED(32'h00000001)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .in_o(in2),
        .sim_begin(sb2), .sim_end(se2), .pair_valid(pv2), .pair_a(pa2), .pair_b(pb2),
        .sim_idx(ix2), .busy(bz2), .done(dn2));

    logic [7:0]  d_in [NI], d_pa [NI], d_pb [NI];
    logic        d_sb [NI], d_se [NI], d_pv [NI], d_bz [NI], d_dn [NI];
    logic [31:0] d_idx [NI];

    assign d_in[0] = in0;  assign d_in[1] = in1;  assign d_in[2] = in2;
    assign d_pa[0] = pa0;  assign d_pa[1] = pa1;  assign d_pa[2] = pa2;
    assign d_pb[0] = pb0;  assign d_pb[1] = pb1;  assign d_pb[2] = pb2;
    assign d_sb[0] = sb0;  assign d_sb[1] = sb1;  assign d_sb[2] = sb2;
    assign d_se[0] = se0;  assign d_se[1] = se1;  assign d_se[2] = se2;
    assign d_pv[0] = pv0;  assign d_pv[1] = pv1;  assign d_pv[2] = pv2;
    assign d_bz[0] = bz0;  assign d_bz[1] = bz1;  assign d_bz[2] = bz2;
    assign d_dn[0] = dn0;  assign d_dn[1] = dn1;  assign d_dn[2] = dn2;
    assign d_idx[0] = 32'(ix0);
    assign d_idx[1] = 32'(ix1);
    assign d_idx[2] = 32'(ix2);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference configuration of each instance.
    function automatic int sim_of(input int k);
        return (k == 0) ? 2 : 3;
    endfunction
    function automatic int hold_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction
    function automatic bit full_of(input int k);
        return k != 2;
    endfunction
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    // Model: a run is a sequence of 2*SIM*SIM phases; phase p belongs to pair p/2,
    // even phases carry A, odd carry B; e counts cycles elapsed inside the phase.
    bit          m_act [NI], m_fin [NI], m_sb [NI], m_se [NI];
    int          m_p [NI], m_e [NI];
    logic [7:0]  m_in [NI], m_cur_a [NI], m_pa [NI], m_pb [NI];
    logic [31:0] m_lfsr [NI];

    task automatic enter_phase(input int k);
        int         pr;
        logic [7:0] v;
        pr = m_p[k] / 2;
        if (full_of(k)) begin
            v = 8'((m_p[k] % 2 == 0) ? pr / sim_of(k) : pr % sim_of(k));
        end else begin
            m_lfsr[k] = lfsr_next(m_lfsr[k]);
            v = m_lfsr[k][7:0];
        end
        m_in[k] = v;
        if (m_p[k] % 2 == 0) m_cur_a[k] = v;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                m_act[k] = 0; m_fin[k] = 0; m_sb[k] = 0; m_se[k] = 0;
                m_p[k] = 0; m_e[k] = 0;
                m_in[k] = '0; m_cur_a[k] = '0; m_pa[k] = '0; m_pb[k] = '0;
                m_lfsr[k] = 32'h1;
            end
        end else if (!pause) begin
            for (int k = 0; k < NI; k++) begin
                m_sb[k] = 0;
                m_se[k] = 0;
                if (m_act[k]) begin
                    if (m_e[k] == hold_of(k) - 1) begin
                        if (m_p[k] % 2 == 0) begin
                            m_sb[k] = 1;
                        end else begin
                            m_se[k] = 1;
                            m_pa[k] = m_cur_a[k];
                            m_pb[k] = m_in[k];
                        end
                        if (m_p[k] == 2 * sim_of(k) * sim_of(k) - 1) begin
                            m_act[k] = 0;
                            m_fin[k] = 1;
                        end else begin
                            m_p[k]++;
                            m_e[k] = 0;
                            enter_phase(k);
                        end
                    end else begin
                        m_e[k]++;
                    end
                end else if (start) begin
                    m_act[k] = 1; m_fin[k] = 0; m_p[k] = 0; m_e[k] = 0;
                    enter_phase(k);
                end
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    initial forever begin
        @(negedge clk);
        #2;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("u%0d.in_o", k),       32'(d_in[k]),  32'(m_in[k]));
            check($sformatf("u%0d.sim_begin", k),  32'(d_sb[k]),  32'(m_sb[k] && !pause));
            check($sformatf("u%0d.sim_end", k),    32'(d_se[k]),  32'(m_se[k] && !pause));
            check($sformatf("u%0d.pair_valid", k), 32'(d_pv[k]),  32'(m_se[k] && !pause));
            check($sformatf("u%0d.pair_a", k),     32'(d_pa[k]),  32'(m_pa[k]));
            check($sformatf("u%0d.pair_b", k),     32'(d_pb[k]),  32'(m_pb[k]));
            check($sformatf("u%0d.sim_idx", k),    d_idx[k],      32'(m_p[k] / 2));
            check($sformatf("u%0d.busy", k),       32'(d_bz[k]),  32'(m_act[k]));
            check($sformatf("u%0d.done", k),       32'(d_dn[k]),  32'(m_fin[k]));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        start = 0;
        pause = 0;
        #1 rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    logic [7:0] t1_exp [8];
    logic [7:0] t3_exp [4];
    logic [7:0] saved;
    int         n_end0, n, pause_left;

    initial begin
        t1_exp = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1};
        t3_exp = '{8'h03, 8'h02, 8'h01, 8'h03};
        rst_n = 0;
        start = 0;
        pause = 0;

        // Reset state
        @(negedge clk);
        #2;
        check("rst.in_o",    32'(in0), 0);
        check("rst.busy",    32'(bz0), 0);
        check("rst.done",    32'(dn0), 0);
        check("rst.sim_idx", 32'(ix0), 0);
        check("rst.sim_end", 32'(se0), 0);
        @(negedge clk);
        rst_n = 1;

        // First run: exhaustive SIM=2 sequence, 3-cycle hold timing, LFSR from seed 1
        pulse_start();
        n_end0 = 0;
        for (int c = 0; c < 9; c++) begin
            #2;
            n_end0 += int'(se0);
            if (c < 8) check($sformatf("t1.in_o[%0d]", c), 32'(in0), 32'(t1_exp[c]));
            if (c < 6) check($sformatf("t2.in_o[%0d]", c), 32'(in1), 0);
            if (c == 2) check("t2.no_early_begin", 32'(sb1), 0);
            if (c == 3) check("t2.begin_after_3", 32'(sb1), 1);
            if (c == 6) check("t2.end_after_6", 32'(se1), 1);
            if (c % 2 == 0 && c < 8)
                check($sformatf("t3.in_o[%0d]", c / 2), 32'(in2), 32'(t3_exp[c / 2]));
            if (c == 4) begin
                check("t3.pair_a", 32'(pa2), 32'h03);
                check("t3.pair_b", 32'(pb2), 32'h02);
            end
            if (c == 8) begin
                check("t1.sim_end_count", 32'(n_end0), 4);
                check("t1.done", 32'(dn0), 1);
                check("t1.sim_idx", 32'(ix0), 3);
            end
            @(negedge clk);
        end
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!(dn0 && dn1 && dn2) && n < 200);
        check("t1.all_done", 32'(dn0 && dn1 && dn2), 1);

        // Restart from DONE, then start while busy
        @(negedge clk);
        start = 1;
        @(negedge clk);
        #2;
        check("t6.restart_idx", 32'(ix0), 0);
        check("t6.restart_busy", 32'(bz0), 1);
        check("t6.restart_in", 32'(in0), 0);
        @(negedge clk);
        start = 0;
        #2;
        check("t6.busy_start_ignored", 32'(sb0), 1);
        check("t6.busy_in", 32'(in0), 0);

        // Pause for 5 cycles inside PH_B of u1
        do_reset();
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!(m_p[1] == 1 && m_e[1] == 0) && n < 100);
        check("t4.reach_ph_b", 32'(n < 100), 1);
        @(negedge clk);
        pause = 1;
        saved = in1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 5) pause = 0;
            #2;
            check($sformatf("t4.in_frozen[%0d]", i), 32'(in1), 32'(saved));
        end
        n = 5;
        while (!se1 && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("t4.end_delay", 32'(n), 7);
        check("t4.pair_count", 32'(ix1), 1);

        // Asynchronous reset in PH_A of pair 7
        do_reset();
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!(m_p[1] == 14 && m_e[1] == 1) && n < 200);
        check("t5.pair7_idx", 32'(ix1), 7);
        check("t5.pair7_busy", 32'(bz1), 1);
        #1 rst_n = 0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("t5.u%0d.in_o", k),    32'(d_in[k]), 0);
            check($sformatf("t5.u%0d.busy", k),    32'(d_bz[k]), 0);
            check($sformatf("t5.u%0d.sim_idx", k), d_idx[k],     0);
            check($sformatf("t5.u%0d.sim_end", k), 32'(d_se[k]), 0);
            check($sformatf("t5.u%0d.pair_a", k),  32'(d_pa[k]), 0);
        end
        @(negedge clk);
        rst_n = 1;
        pulse_start();
        #2;
        check("t5.restart_idx", 32'(ix1), 0);
        check("t5.restart_in", 32'(in1), 0);
        check("t5.restart_busy", 32'(bz1), 1);

        // Randomized start/pause/reset traffic, checked by the model every cycle
        pause_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1;
            start = ($urandom_range(0, 9) == 0);
            if (pause_left > 0) begin
                pause = 1;
                pause_left--;
            end else begin
                pause = 0;
                if ($urandom_range(0, 14) == 0) pause_left = int'($urandom_range(1, 6));
            end
            if ($urandom_range(0, 499) == 0) #1 rst_n = 0;
        end

        @(negedge clk);
        start = 0;
        pause = 0;
        rst_n = 1;
        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
